// File: rtl/tfe_pkg.sv
// Shared types and sizing helpers for the TensorFlowE MAC engine.
// Optional feature macro: TFE_SATURATE_EN (saturating accumulate).
package tfe_pkg;

    localparam int TFE_DATA_W = 8;
    localparam int TFE_ACC_W  = 24;
    localparam int TFE_DEPTH  = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } tfe_state_t;

    function automatic int nbeats(input int acc_w, input int data_w);
        return acc_w / data_w;
    endfunction

    function automatic int prod_w(input int data_w);
        return 2 * data_w;
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/tfe_weight_buf.sv
// Weight register file: one write port, one combinational read port.
// Storage is intentionally not reset.
module tfe_weight_buf
    import tfe_pkg::*;
#(
    parameter int DATA_W = TFE_DATA_W,
    parameter int DEPTH  = TFE_DEPTH,
    parameter int PTR_W  = ptr_w(TFE_DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write one weight per enabled cycle
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tfe_mac_engine.sv
// TensorFlowE MAC engine: weight buffer, 2-stage MAC pipeline, drain shifter.
// Optional feature macro: TFE_SATURATE_EN (clamp accumulator, sticky sat_flag).
module tfe_mac_engine
    import tfe_pkg::*;
#(
    parameter int DATA_W = TFE_DATA_W,
    parameter int ACC_W  = TFE_ACC_W,
    parameter int DEPTH  = TFE_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              wr_en,
    input  logic              acc_en,
    input  logic              rd_en,
    input  logic              clear,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              busy,
    output logic              acc_done,
    output logic              sat_flag
);

    localparam int PROD_W = prod_w(DATA_W);
    localparam int PTR_W  = ptr_w(DEPTH);
    localparam int NBEATS = nbeats(ACC_W, DATA_W);
    localparam int CNT_W  = $clog2(NBEATS + 1);

    tfe_state_t               state;
    logic [PTR_W-1:0]         w_ptr;
    logic [PTR_W-1:0]         a_ptr;
    logic [PTR_W:0]           w_count;
    logic [PTR_W:0]           w_last;
    logic [DATA_W-1:0]        w_rdata;
    logic                     s1_valid;
    logic                     s1_last;
    logic signed [PROD_W-1:0] s1_prod;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic [ACC_W-1:0]         shreg;
    logic [CNT_W-1:0]         beat_left;
    logic                     do_rd;
    logic                     do_acc;
    logic                     do_wr;
    logic                     a_at_last;

    assign busy   = (state == DRAIN) | s1_valid;
    assign do_rd  = !clear && rd_en && !busy;
    assign do_acc = !clear && !rd_en && acc_en
                    && (state == IDLE) && (w_count != '0);
    assign do_wr  = !clear && !rd_en && !acc_en && wr_en
                    && (state == IDLE);

    assign w_last    = w_count - (PTR_W+1)'(1);
    assign a_at_last = ({1'b0, a_ptr} == w_last);

    tfe_weight_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_wbuf (
        .clk   (clk),
        .we    (do_wr),
        .waddr (w_ptr),
        .wdata (data_in),
        .raddr (a_ptr),
        .rdata (w_rdata)
    );

`ifdef TFE_SATURATE_EN
    logic signed [ACC_W:0] sum_w;
    logic                  sat_hit;

    // Widened add, then clamp to the signed accumulator range
    always_comb begin
        sum_w    = (ACC_W+1)'(acc) + (ACC_W+1)'(s1_prod);
        sat_hit  = 1'b0;
        acc_next = sum_w[ACC_W-1:0];
        if (sum_w[ACC_W] != sum_w[ACC_W-1]) begin
            sat_hit  = 1'b1;
            acc_next = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                    : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    // Sticky saturation indicator, cleared only by clear or reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_flag <= 1'b0;
        end else if (clear) begin
            sat_flag <= 1'b0;
        end else if (s1_valid && sat_hit) begin
            sat_flag <= 1'b1;
        end
    end
`else
    // Modular accumulate
    always_comb begin
        acc_next = acc + ACC_W'(s1_prod);
    end

    assign sat_flag = 1'b0;
`endif

    // Weight write pointer and loaded-entry count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr   <= '0;
            w_count <= '0;
        end else if (do_wr) begin
            w_ptr <= w_ptr + PTR_W'(1);
            if (w_count != (PTR_W+1)'(DEPTH)) begin
                w_count <= w_count + (PTR_W+1)'(1);
            end
        end
    end

    // MAC pipeline: stage1 multiply, stage2 accumulate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_ptr    <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_prod  <= '0;
            acc      <= '0;
            acc_done <= 1'b0;
        end else if (clear) begin
            a_ptr    <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            acc      <= '0;
            acc_done <= 1'b0;
        end else begin
            acc_done <= s1_valid & s1_last;
            if (s1_valid) begin
                acc <= acc_next;
            end
            s1_valid <= do_acc;
            if (do_acc) begin
                s1_prod <= $signed(data_in) * $signed(w_rdata);
                s1_last <= a_at_last;
                a_ptr   <= a_at_last ? '0 : a_ptr + PTR_W'(1);
            end
        end
    end

    // Drain FSM: snapshot acc and shift it out LS slice first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            beat_left <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            beat_left <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (do_rd) begin
                        state     <= DRAIN;
                        data_out  <= acc[DATA_W-1:0];
                        shreg     <= $unsigned(acc) >> DATA_W;
                        beat_left <= CNT_W'(NBEATS - 1);
                        out_valid <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (beat_left == '0) begin
                        state     <= IDLE;
                        data_out  <= '0;
                        out_valid <= 1'b0;
                    end else begin
                        data_out  <= shreg[DATA_W-1:0];
                        shreg     <= shreg >> DATA_W;
                        beat_left <= beat_left - CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule
